// File: rtl/decoder_2x4_using_case_statement_pkg.sv
// Shared widths, reset constant and one-hot decode function for the 2-to-4 decoder.
// Used by the interface, the combinational core and the top.
package decoder_pkg;

    localparam int SEL_W = 2;
    localparam int OUT_W = 4;

    localparam logic [OUT_W-1:0] Y_RST = '0;

    // Unknown selects fall through to all-zero so strobes never fire on X/Z.
    function automatic logic [OUT_W-1:0] onehot_decode(input logic [SEL_W-1:0] sel);
        case (sel)
            2'b00:   onehot_decode = 4'b0001;
            2'b01:   onehot_decode = 4'b0010;
            2'b10:   onehot_decode = 4'b0100;
            2'b11:   onehot_decode = 4'b1000;
            default: onehot_decode = Y_RST;
        endcase
    endfunction

endpackage

// File: rtl/decoder_2x4_using_case_statement_if.sv
// Select/enable/decoded-output bundle between a select source and the decoder.
// Master drives a/en, slave (the decoder) drives y.
interface decoder_2x4_using_case_statement_if;

    logic [decoder_pkg::SEL_W-1:0] a;
    logic                          en;
    logic [decoder_pkg::OUT_W-1:0] y;

    modport master (output a, output en, input  y);
    modport slave  (input  a, input  en, output y);

endinterface

// File: rtl/decoder_2x4_using_case_statement_dec2x4.sv
// Pure combinational 2-to-4 case decoder with active-high enable.
// No state; every path assigns the output.
import decoder_pkg::*;

module dec2x4_comb (
    input  logic [SEL_W-1:0] i_a,
    input  logic             i_en,
    output logic [OUT_W-1:0] o_y_next
);

    always_comb begin
        o_y_next = Y_RST;
        if (i_en) begin
            o_y_next = onehot_decode(i_a);
        end
    end

endmodule

// File: rtl/decoder_2x4_using_case_statement.sv
// 2-to-4 one-hot decoder with optional output register (OUT_REG) and, when the
// DEC_HOLD_EN macro is defined, a hold register that keeps y while en is low.
import decoder_pkg::*;

module decoder_2x4_using_case_statement #(
    parameter int OUT_REG = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    decoder_2x4_using_case_statement_if.slave     bus
);

    logic [OUT_W-1:0] w_y_next;

`ifdef DEC_HOLD_EN
    logic [OUT_W-1:0] r_hold;

    // Decode with enable forced high; en only gates whether the hold register loads.
    dec2x4_comb u_dec (
        .i_a      (bus.a),
        .i_en     (1'b1),
        .o_y_next (w_y_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= Y_RST;
        end else if (bus.en) begin
            r_hold <= w_y_next;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        assign bus.y = r_hold;
    end else begin : g_out_comb
        assign bus.y = bus.en ? w_y_next : r_hold;
    end
`else
    dec2x4_comb u_dec (
        .i_a      (bus.a),
        .i_en     (bus.en),
        .o_y_next (w_y_next)
    );

    if (OUT_REG != 0) begin : g_out_reg
        logic [OUT_W-1:0] r_y;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_y <= Y_RST;
            end else begin
                r_y <= w_y_next;
            end
        end

        assign bus.y = r_y;
    end else begin : g_out_comb
        // Purely combinational build: clock and reset are intentionally unused here.
        logic w_unused_clk_rst;
        assign w_unused_clk_rst = clk ^ rst;
        assign bus.y = w_y_next;
    end
`endif

endmodule

// File: tb/tb_decoder_2x4_using_case_statement.sv
// Self-checking bench: registered (OUT_REG=1) and combinational (OUT_REG=0) decoders
// driven in lockstep by a directed table, then random stimulus against a reference model.
module tb_decoder_2x4_using_case_statement;

    logic clk;
    logic rst;

    decoder_2x4_using_case_statement_if bus_r ();
    decoder_2x4_using_case_statement_if bus_c ();

    decoder_2x4_using_case_statement #(.OUT_REG(1)) u_dut_reg (
        .clk (clk),
        .rst (rst),
        .bus (bus_r)
    );

    decoder_2x4_using_case_statement #(.OUT_REG(0)) u_dut_comb (
        .clk (clk),
        .rst (rst),
        .bus (bus_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DEC_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic [1:0] a;
        logic       en;
        logic [3:0] exp_y;
    } vec_t;

    vec_t tbl[10];

    int pass_cnt = 0;
    int total    = 0;
    bit started  = 1'b0;

    // Reference state: value y should show after an edge / value held for en=0.
    logic [3:0] exp_r  = 4'b0000;
    logic [3:0] hold_m = 4'b0000;

    function automatic logic [3:0] ref_decode(input logic [1:0] a);
        return 4'(1 << int'(a));
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            total++;
            if ($countones(bus_r.y) <= 1 && !$isunknown(bus_r.y)) pass_cnt++;
            else $display("FAIL onehot_reg: got %b expected at most one bit set", bus_r.y);
            total++;
            if ($countones(bus_c.y) <= 1 && !$isunknown(bus_c.y)) pass_cnt++;
            else $display("FAIL onehot_comb: got %b expected at most one bit set", bus_c.y);
        end
    end

    // Apply one cycle of stimulus, check the combinational DUT before the edge and
    // the registered DUT after it.
    task automatic run_cycle(input logic r, input logic [1:0] a, input logic en,
                             input bit use_tbl, input logic [3:0] tbl_exp);
        logic [3:0] exp_c;
        rst = r;
        bus_r.a = a;  bus_r.en = en;
        bus_c.a = a;  bus_c.en = en;
        #1;
        exp_c = en ? ref_decode(a) : (HOLD ? hold_m : 4'b0000);
        chk("comb_y", bus_c.y, exp_c);
        @(posedge clk);
        #1;
        if (r) begin
            exp_r  = 4'b0000;
            hold_m = 4'b0000;
        end else if (en) begin
            exp_r  = ref_decode(a);
            hold_m = ref_decode(a);
        end else begin
            exp_r = HOLD ? hold_m : 4'b0000;
        end
        chk(use_tbl ? "tbl_reg_y" : "rand_reg_y", bus_r.y, use_tbl ? tbl_exp : exp_r);
    endtask

    initial begin
        rst = 1'b1;
        bus_r.a = 2'b11; bus_r.en = 1'b1;
        bus_c.a = 2'b11; bus_c.en = 1'b1;

`ifdef DEC_HOLD_EN
        tbl[0] = '{1'b1, 2'b11, 1'b1, 4'b0000};
        tbl[1] = '{1'b1, 2'b11, 1'b1, 4'b0000};
        tbl[2] = '{1'b0, 2'b11, 1'b1, 4'b1000};
        tbl[3] = '{1'b0, 2'b01, 1'b1, 4'b0010};
        tbl[4] = '{1'b0, 2'b11, 1'b0, 4'b0010};
        tbl[5] = '{1'b0, 2'b11, 1'b0, 4'b0010};
        tbl[6] = '{1'b0, 2'b11, 1'b0, 4'b0010};
        tbl[7] = '{1'b1, 2'b11, 1'b0, 4'b0000};
        tbl[8] = '{1'b0, 2'b00, 1'b1, 4'b0001};
        tbl[9] = '{1'b0, 2'b10, 1'b0, 4'b0001};
`else
        tbl[0] = '{1'b1, 2'b11, 1'b1, 4'b0000};
        tbl[1] = '{1'b1, 2'b11, 1'b1, 4'b0000};
        tbl[2] = '{1'b0, 2'b11, 1'b1, 4'b1000};
        tbl[3] = '{1'b0, 2'b11, 1'b0, 4'b0000};
        tbl[4] = '{1'b0, 2'b00, 1'b1, 4'b0001};
        tbl[5] = '{1'b0, 2'b01, 1'b1, 4'b0010};
        tbl[6] = '{1'b0, 2'b10, 1'b1, 4'b0100};
        tbl[7] = '{1'b0, 2'b11, 1'b1, 4'b1000};
        tbl[8] = '{1'b1, 2'b10, 1'b1, 4'b0000};
        tbl[9] = '{1'b0, 2'b10, 1'b1, 4'b0100};
`endif

        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            run_cycle(tbl[i].rst, tbl[i].a, tbl[i].en, 1'b1, tbl[i].exp_y);
            started = 1'b1;
        end

        // Combinational path responds with no clock edge in between.
        bus_c.a = 2'b10; bus_c.en = 1'b1;
        #1;
        chk("comb_no_edge_on", bus_c.y, 4'b0100);
        bus_c.en = 1'b0;
        #1;
        chk("comb_no_edge_off", bus_c.y, HOLD ? hold_m : 4'b0000);

        for (int i = 0; i < 300; i++) begin
            run_cycle(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 3) != 0), 1'b0, 4'b0000);
        end

        started = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
